// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a one-word hold buffer.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   pc                PC register value, sampled when a request is issued
//   flush             redirect; drops IF/ID, the hold buffer and any in-flight word
//   id_stall          decode cannot accept; the IF/ID register holds
//   imem_req/addr     memory request, held with a stable address until imem_ack
//   imem_ack/rdata    memory response (latency 1..N)
//   pc_stall          low for exactly the cycles the PC may advance
//   ifid_*            IF/ID register: valid, instruction, pc, pc+4
module fetch_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        pc_stall,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4
);

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state_q;
    logic [31:0] req_addr_q;
    logic [31:0] hold_q;
    logic        hold_valid_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;

    logic        slot_free;
    logic [31:0] req_addr_p4;

    // IF/ID can take a word if it is empty or being consumed this cycle.
    assign slot_free   = !valid_q || !id_stall;
    assign req_addr_p4 = req_addr_q + 32'd4;

    // Reset masks the request so a stale WAIT/DRAIN state never leaks out.
    assign imem_req  = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && !reset;
    assign imem_addr = req_addr_q;

    assign ifid_valid = valid_q;
    assign ifid_instr = instr_q;
    assign ifid_pc    = pc_q;
    assign ifid_pc4   = pc4_q;

    // The PC advances only when a word enters IF/ID, or on a redirect.
    always_comb begin
        pc_stall = 1'b1;
        if (reset) begin
            pc_stall = 1'b1;
        end else if (flush) begin
            pc_stall = 1'b0;
        end else begin
            case (state_q)
                S_WAIT:  pc_stall = !(imem_ack && slot_free);
                S_HOLD:  pc_stall = id_stall;
                default: pc_stall = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_ISSUE;
            req_addr_q   <= 32'h0;
            hold_q       <= 32'h0;
            hold_valid_q <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0;
            pc_q         <= 32'h0;
            pc4_q        <= 32'h0;
        end else if (flush) begin
            valid_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            // An unanswered request must still be drained; everything
            // else restarts from the redirect target.
            case (state_q)
                S_WAIT:  state_q <= imem_ack ? S_ISSUE : S_DRAIN;
                S_DRAIN: state_q <= imem_ack ? S_ISSUE : S_DRAIN;
                default: state_q <= S_ISSUE;
            endcase
        end else begin
            if (!id_stall) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                S_ISSUE: begin
                    req_addr_q <= pc;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        if (slot_free) begin
                            valid_q <= 1'b1;
                            instr_q <= imem_rdata;
                            pc_q    <= req_addr_q;
                            pc4_q   <= req_addr_p4;
                            state_q <= S_ISSUE;
                        end else begin
                            hold_q       <= imem_rdata;
                            hold_valid_q <= 1'b1;
                            state_q      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!id_stall && hold_valid_q) begin
                        valid_q      <= 1'b1;
                        instr_q      <= hold_q;
                        pc_q         <= req_addr_q;
                        pc4_q        <= req_addr_p4;
                        hold_valid_q <= 1'b0;
                        state_q      <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        state_q <= S_ISSUE;
                    end
                end
                default: state_q <= S_ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a transaction model.
// Ports: none (drives clock, reset, PC register and a latency-N memory).
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic        id_stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_stall;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;

    logic [31:0] target = 32'h0;
    logic        ack_force = 1'b0;
    logic        mon_on = 1'b0;
    int          lat = 1;
    int          cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    // Transaction-level model of the fetch stage.
    logic        m_req = 1'b0;
    logic        m_drop = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic        m_bv = 1'b0;
    logic [31:0] m_buf = 32'h0;
    logic        m_fv = 1'b0;
    logic [31:0] m_fi = 32'h0;
    logic [31:0] m_fp = 32'h0;
    logic [31:0] m_f4 = 32'h0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h13;
    endfunction

    assign imem_ack   = ack_force | (imem_req & (cnt >= lat));
    assign imem_rdata = imem_req ? mem(imem_addr) : 32'hBAD0_BAD0;

    fetch_unit dut (
        .clock      (clock),
        .reset      (reset),
        .pc         (pc),
        .flush      (flush),
        .id_stall   (id_stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_stall   (pc_stall),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock: the PC register and memory latency counter advance.
    task automatic cyc();
        logic st;
        logic fl;
        logic rs;
        @(negedge clock);
        st = pc_stall;
        fl = flush;
        rs = reset;
        @(posedge clock);
        #1;
        if (!rs) begin
            if (fl) pc = target;
            else if (!st) pc = pc + 32'd4;
        end
        if (imem_req === 1'b1) cnt++;
        else cnt = 0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic restart(input logic [31:0] v);
        flush = 1'b0;
        ack_force = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        pc = v;
    endtask

    // Compare DUT against the model every cycle, then advance the model.
    initial begin
        logic e_stall;
        logic free;
        forever begin
            @(negedge clock);
            if (mon_on) begin
                if (reset) e_stall = 1'b1;
                else if (flush) e_stall = 1'b0;
                else if (m_req && !m_drop && imem_ack && (!m_fv || !id_stall))
                    e_stall = 1'b0;
                else if (m_bv && !id_stall) e_stall = 1'b0;
                else e_stall = 1'b1;
                chk("m_pc_stall", {31'b0, pc_stall}, {31'b0, e_stall});
                chk("m_imem_req", {31'b0, imem_req}, {31'b0, m_req && !reset});
                chk("m_imem_addr", imem_addr, m_addr);
                chk("m_ifid_valid", {31'b0, ifid_valid}, {31'b0, m_fv});
                chk("m_ifid_instr", ifid_instr, m_fi);
                chk("m_ifid_pc", ifid_pc, m_fp);
                chk("m_ifid_pc4", ifid_pc4, m_f4);

                if (reset) begin
                    m_req = 0; m_drop = 0; m_addr = 0; m_bv = 0; m_buf = 0;
                    m_fv = 0; m_fi = 0; m_fp = 0; m_f4 = 0;
                end else if (flush) begin
                    m_fv = 0;
                    m_bv = 0;
                    if (m_req && !imem_ack) m_drop = 1;
                    else begin m_req = 0; m_drop = 0; end
                end else begin
                    free = !m_fv || !id_stall;
                    if (!id_stall) m_fv = 0;
                    if (m_bv) begin
                        if (!id_stall) begin
                            m_fv = 1; m_fi = m_buf;
                            m_fp = m_addr; m_f4 = m_addr + 32'd4;
                            m_bv = 0;
                        end
                    end else if (!m_req) begin
                        m_req = 1; m_drop = 0; m_addr = pc;
                    end else if (imem_ack) begin
                        m_req = 0;
                        if (m_drop) m_drop = 0;
                        else if (free) begin
                            m_fv = 1; m_fi = imem_rdata;
                            m_fp = m_addr; m_f4 = m_addr + 32'd4;
                        end else begin
                            m_buf = imem_rdata; m_bv = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int zeros;
        // Reset values.
        reset = 1'b1;
        cyc();
        mon_on = 1'b1;
        settle();
        chk("rst_pc_stall", {31'b0, pc_stall}, 32'd1);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_ifid_instr", ifid_instr, 32'h0);
        chk("rst_ifid_pc4", ifid_pc4, 32'h0);
        cyc();

        // 1-cycle memory, streaming fetch.
        lat = 1; id_stall = 0;
        restart(32'h100);
        settle();
        chk("s1_issue_req", {31'b0, imem_req}, 32'd0);
        chk("s1_issue_stall", {31'b0, pc_stall}, 32'd1);
        cyc();
        settle();
        chk("s1_wait_req", {31'b0, imem_req}, 32'd1);
        chk("s1_wait_addr", imem_addr, 32'h100);
        chk("s1_wait_stall", {31'b0, pc_stall}, 32'd0);
        cyc();
        settle();
        chk("s1_valid", {31'b0, ifid_valid}, 32'd1);
        chk("s1_instr", ifid_instr, 32'h5A5A_0113);
        chk("s1_pc", ifid_pc, 32'h100);
        chk("s1_pc4", ifid_pc4, 32'h104);
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) settle();
            zeros += (pc_stall === 1'b0) ? 1 : 0;
            cyc();
        end
        chk("s1_throughput", zeros, 32'd4);
        settle();
        chk("s1_last_pc", ifid_pc, 32'h110);

        // 3-cycle ack latency.
        lat = 3;
        restart(32'h200);
        cyc();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("s2_req", {31'b0, imem_req}, 32'd1);
            chk("s2_addr", imem_addr, 32'h200);
            chk("s2_stall", {31'b0, pc_stall}, (i == 2) ? 32'd0 : 32'd1);
            cyc();
        end
        settle();
        chk("s2_pc", ifid_pc, 32'h200);

        // Ack while decode is stalled goes through the hold buffer.
        lat = 1;
        restart(32'h300);
        cyc();
        cyc();
        id_stall = 1;
        cyc();
        settle();
        chk("s3_busy_stall", {31'b0, pc_stall}, 32'd1);
        cyc();
        settle();
        chk("s3_hold_req", {31'b0, imem_req}, 32'd0);
        chk("s3_hold_pc", ifid_pc, 32'h300);
        chk("s3_hold_stall", {31'b0, pc_stall}, 32'd1);
        cyc();
        id_stall = 0;
        settle();
        chk("s3_release_stall", {31'b0, pc_stall}, 32'd0);
        cyc();
        settle();
        chk("s3_buf_pc", ifid_pc, 32'h304);
        chk("s3_buf_instr", ifid_instr, 32'h5A5A_0317);
        chk("s3_buf_valid", {31'b0, ifid_valid}, 32'd1);

        // Flush before ack: drain, then fetch the redirect target.
        lat = 3;
        restart(32'h400);
        cyc();
        flush = 1; target = 32'h800;
        settle();
        chk("s4_flush_stall", {31'b0, pc_stall}, 32'd0);
        cyc();
        flush = 0;
        settle();
        chk("s4_drain_valid", {31'b0, ifid_valid}, 32'd0);
        chk("s4_drain_req", {31'b0, imem_req}, 32'd1);
        chk("s4_drain_addr", imem_addr, 32'h400);
        chk("s4_drain_stall", {31'b0, pc_stall}, 32'd1);
        cyc();
        settle();
        chk("s4_drain_ack_stall", {31'b0, pc_stall}, 32'd1);
        cyc();
        cyc();
        settle();
        chk("s4_new_addr", imem_addr, 32'h800);
        cyc();
        cyc();
        cyc();
        settle();
        chk("s4_new_pc", ifid_pc, 32'h800);
        chk("s4_new_instr", ifid_instr, 32'h5A5A_0813);

        // Flush together with ack.
        lat = 1;
        restart(32'h500);
        cyc();
        flush = 1; target = 32'h900;
        settle();
        chk("s5_flush_stall", {31'b0, pc_stall}, 32'd0);
        cyc();
        flush = 0;
        settle();
        chk("s5_valid", {31'b0, ifid_valid}, 32'd0);
        chk("s5_req", {31'b0, imem_req}, 32'd0);
        chk("s5_instr", ifid_instr, 32'h0);
        cyc();
        settle();
        chk("s5_new_addr", imem_addr, 32'h900);
        cyc();

        // pc+4 wraps at the top of the address space.
        restart(32'hFFFF_FFFC);
        cyc();
        cyc();
        settle();
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc4, 32'h0);
        chk("wrap_instr", ifid_instr, 32'hA5A6_000F);

        // Reset mid-request; the late ack is ignored.
        lat = 2;
        restart(32'h600);
        cyc();
        reset = 1;
        settle();
        chk("s6_rst_stall", {31'b0, pc_stall}, 32'd1);
        chk("s6_rst_req", {31'b0, imem_req}, 32'd0);
        cyc();
        reset = 0;
        ack_force = 1;
        settle();
        chk("s6_late_req", {31'b0, imem_req}, 32'd0);
        chk("s6_late_valid", {31'b0, ifid_valid}, 32'd0);
        chk("s6_late_pc", ifid_pc, 32'h0);
        cyc();
        ack_force = 0;
        settle();
        chk("s6_restart_req", {31'b0, imem_req}, 32'd1);
        chk("s6_restart_addr", imem_addr, 32'h600);
        cyc();
        cyc();
        settle();
        chk("s6_restart_pc", ifid_pc, 32'h600);

        // Mixed stall/flush traffic, checked by the model only.
        for (int i = 0; i < 24; i++) begin
            id_stall = (i % 3 == 0);
            flush = (i == 11);
            target = 32'hA00;
            cyc();
        end
        id_stall = 0;
        flush = 0;
        for (int i = 0; i < 6; i++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
